div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle 32-bit integer divider built on repeated shift-subtract; the subtractive counterpart to the ALU's combinational adder.
- Same operand and flag conventions as the adder: A, B, sign, and Z/N/C/V.
- Sits beside the adder in the ALU datapath.
- Start/busy/done handshake so the control unit can stall while the divider iterates.

Parameters:
- WIDTH, 32, operand, quotient and remainder width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a division; sampled only in IDLE.
- A  in  WIDTH  dividend.
- B  in  WIDTH  divisor.
- sign  in  1  1 = two's-complement operands, 0 = unsigned.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- cociente  out  WIDTH  quotient.
- residuo  out  WIDTH  remainder.
- Z  out  1  quotient == 0.
- N  out  1  quotient[WIDTH-1] when sign=1; always 0 when sign=0.
- C  out  1  remainder != 0 (inexact result).
- V  out  1  divide-by-zero, or signed overflow (-2^31 / -1).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, cociente, residuo, Z, N, C, V all 0; counter 0.
- States: IDLE, DIV, FIX, DONE.
- IDLE, start=1:
  - Capture A, B, sign.
  - If B==0, or sign=1 with A==0x80000000 and B==0xFFFFFFFF: go to FIX with the special flag set.
  - Otherwise: load |A| and |B| (magnitudes only when sign=1), clear the partial remainder, counter=0, go to DIV.
- DIV, one restoring step per cycle:
  - rem' = {rem[WIDTH-2:0], dividend MSB}; shift dividend left.
  - If rem' >= divisor: rem = rem' - divisor and shift in quotient bit 1; else shift in 0.
  - counter++; after WIDTH steps (counter==WIDTH-1 step completes) go to FIX.
- FIX, normal path:
  - Quotient negated if sign=1 and A[31]^B[31].
  - Remainder negated if sign=1 and A[31] (remainder takes the sign of the dividend; truncating division).
- FIX, special results:
  - Divide-by-zero: cociente=0xFFFFFFFF, residuo=A, V=1.
  - Signed overflow: cociente=0x80000000, residuo=0, V=1.
- DONE:
  - Output registers and flags are written on entry to DONE; done=1 for exactly this cycle.
  - Next cycle return to IDLE.
- Outputs hold their values until the next DONE; they are not cleared by a new start.
- busy: 1 in DIV, FIX and DONE; 0 in IDLE.
- Latency, measured from the edge that samples start (cycle 0):
  - Normal path: done at cycle 34.
  - Special cases: done at cycle 2.
- start while busy: ignored, with no queuing.
- start held high: a new operation is accepted on the first IDLE cycle after DONE.
- A, B and sign may change after acceptance without affecting the running operation.
- Reset asserted mid-operation: immediate return to reset values; no done pulse for the aborted operation.
- Flags are computed from the final (sign-corrected) values; Z and C may both be 1.

Decomposition:
- Package div_pkg holds:
  - WIDTH default.
  - State encoding: IDLE=2'd0, DIV=2'd1, FIX=2'd2, DONE=2'd3.
  - Constants INT_MIN=0x80000000 and ALL_ONES=0xFFFFFFFF.
- One combinational sub-module, div_step, performs one shift-compare-subtract:
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
  - The FSM, counter and sign fix-up stay in div_seq.

Test Plan:
- Unsigned A=100, B=7, sign=0 -> done at cycle 34; cociente=14, residuo=2; Z=0 N=0 C=1 V=0; busy high cycles 1-34.
- Signed A=0xFFFFFF9C (-100), B=7, sign=1 -> cociente=0xFFFFFFF2 (-14), residuo=0xFFFFFFFE (-2); N=1 C=1 Z=0 V=0.
- Divide-by-zero A=5, B=0, sign=0 -> done at cycle 2; cociente=0xFFFFFFFF, residuo=5, V=1.
- A=0x80000000, B=0xFFFFFFFF:
  - sign=1 -> cociente=0x80000000, residuo=0, V=1, N=1.
  - Same operands, sign=0 -> cociente=0, residuo=0x80000000, Z=1, C=1, V=0.
- Start A=100, B=7; pulse start again at cycle 5 with A=9, B=3; drop rst_n at cycle 10:
  - The cycle-5 start is ignored.
  - At reset, busy=0 and all outputs are 0 immediately, with no done pulse.
  - After release, A=9, B=3 completes at cycle 34 with cociente=3, residuo=0, C=0.
- A=0, B=3, sign=1 -> cociente=0, residuo=0; Z=1, N=0, C=0, V=0.
- Back-to-back with start held high: second operation is accepted the cycle after DONE; first results remain stable until the second done.

Source files
------------

// File: rtl/div_pkg.sv
// ---- div_pkg : shared types and constants for the sequential divider, rev 1.0 ----
`default_nettype none

package div_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [WIDTH-1:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ---- div_step : one restoring shift-compare-subtract step, rev 1.0 ----
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;

  // rem < divisor always holds, so the extra top bit of the difference is a clean borrow.
  assign w_shifted = {rem, msb};
  assign w_diff    = w_shifted - {1'b0, divisor};
  assign q_bit     = ~w_diff[WIDTH];
  assign rem_next  = q_bit ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ---- div_seq : multi-cycle signed/unsigned divider with start/busy/done handshake, rev 1.0 ----
`default_nettype none

module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = div_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] residuo,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_ONES = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH-1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_a;
  logic             r_sign;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz;
  logic             r_ov;

  logic             w_dz;
  logic             w_ov;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;

  assign w_dz    = (B == '0);
  assign w_ov    = sign && (A == C_MIN) && (B == C_ONES);
  assign w_a_mag = (sign && A[WIDTH-1]) ? -A : A;
  assign w_b_mag = (sign && B[WIDTH-1]) ? -B : B;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_rem),
    .msb      (r_dvd[WIDTH-1]),
    .divisor  (r_dvs),
    .rem_next (w_rem_next),
    .q_bit    (w_q_bit)
  );

  // The dividend register doubles as the quotient: bits shift out the top, quotient bits in the bottom.
  always_comb begin
    w_q = r_q_neg ? -r_dvd : r_dvd;
    w_r = r_r_neg ? -r_rem : r_rem;
    if (r_dz) begin
      w_q = C_ONES;
      w_r = r_a;
    end else if (r_ov) begin
      w_q = C_MIN;
      w_r = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_a      <= '0;
      r_sign   <= 1'b0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_dz     <= 1'b0;
      r_ov     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cociente <= '0;
      residuo  <= '0;
      Z        <= 1'b0;
      N        <= 1'b0;
      C        <= 1'b0;
      V        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= A;
            r_sign  <= sign;
            r_q_neg <= sign & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_r_neg <= sign & A[WIDTH-1];
            r_dz    <= w_dz;
            r_ov    <= w_ov;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_dvd   <= w_a_mag;
            r_dvs   <= w_b_mag;
            busy    <= 1'b1;
            r_state <= (w_dz || w_ov) ? FIX : DIV;
          end
        end
        DIV: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[WIDTH-2:0], w_q_bit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          cociente <= w_q;
          residuo  <= w_r;
          Z        <= (w_q == '0);
          N        <= r_sign & w_q[WIDTH-1];
          C        <= (w_r != '0);
          V        <= r_dz | r_ov;
          done     <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ---- tb_div_seq : self-checking bench for div_seq against an arithmetic reference, rev 1.0 ----
`default_nettype none

module tb_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        sign;
  logic        busy;
  logic        done;
  logic [31:0] cociente;
  logic [31:0] residuo;
  logic        Z;
  logic        N;
  logic        C;
  logic        V;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .sign     (sign),
    .busy     (busy),
    .done     (done),
    .cociente (cociente),
    .residuo  (residuo),
    .Z        (Z),
    .N        (N),
    .C        (C),
    .V        (V)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the special cases layered on top; flags packed {Z,N,C,V}.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic [3:0] f, output int lat);
    int  sa;
    int  sb;
    logic v;
    sa = a;
    sb = b;
    v  = 1'b0;
    lat = 34;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; v = 1'b1; lat = 2;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; v = 1'b1; lat = 2;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    f = {q == 32'd0, s & q[31], r != 32'd0, v};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic [3:0]  ef;
    int          exp_lat;
    int          lat;
    bit          busy_ok;
    model(a, b, s, eq, er, ef, exp_lat);
    @(negedge clk);
    A = a; B = b; sign = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; A = $urandom; B = $urandom; sign = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, ".latency"}, 128'(lat), 128'(exp_lat));
    check({tag, ".busy"}, 128'(busy_ok), 128'(1));
    check({tag, ".cociente"}, 128'(cociente), 128'(eq));
    check({tag, ".residuo"}, 128'(residuo), 128'(er));
    check({tag, ".flags"}, 128'({Z, N, C, V}), 128'(ef));
    @(negedge clk);
    check({tag, ".after_done"}, 128'({busy, done}), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [31:0] q1;
    logic [31:0] r1;
    bit          seen_done;
    bit          stable_ok;
    int          lat2;

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; sign = 1'b0;
    #3;
    check("reset.state", 128'({busy, done, cociente, residuo, Z, N, C, V}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, "unsigned_100_7");
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, "signed_m100_7");
    run_op(32'd5, 32'd0, 1'b0, "div_by_zero");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "signed_overflow");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "unsigned_min_ones");
    run_op(32'd0, 32'd3, 1'b1, "zero_dividend");

    // Abort mid-operation: an extra start is ignored, then reset clears everything at once.
    @(negedge clk);
    A = 32'd100; B = 32'd7; sign = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen_done = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
      if (k == 5) begin A = 32'd9; B = 32'd3; start = 1'b1; end
      if (k == 6) start = 1'b0;
      if (k == 9) check("abort.busy_before_rst", 128'(busy), 128'(1));
    end
    rst_n = 1'b0;
    #1;
    check("abort.no_done", 128'(seen_done), 128'(0));
    check("abort.outputs", 128'({busy, done, cociente, residuo, Z, N, C, V}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd9, 32'd3, 1'b0, "after_reset_9_3");

    // Back-to-back with start held high; first results must hold until the second done.
    @(negedge clk);
    A = 32'd100; B = 32'd7; sign = 1'b0; start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) break;
    end
    check("b2b.first_done", 128'(done), 128'(1));
    q1 = cociente; r1 = residuo;
    check("b2b.first_q", 128'({q1, r1}), 128'({32'd14, 32'd2}));
    A = 32'hFFFF_FF9C; B = 32'd7; sign = 1'b1;
    stable_ok = 1'b1;
    lat2 = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) check("b2b.idle_gap", 128'(busy), 128'(0));
      if (done) begin
        lat2 = k;
        break;
      end
      if (cociente !== q1 || residuo !== r1) stable_ok = 1'b0;
    end
    start = 1'b0;
    check("b2b.second_latency", 128'(lat2), 128'(35));
    check("b2b.stable", 128'(stable_ok), 128'(1));
    check("b2b.second_result", 128'({cociente, residuo}), 128'({32'hFFFF_FFF2, 32'hFFFF_FFFE}));
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      ra = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = $urandom | 32'h8000_0000;
        default: rb = ($urandom >> $urandom_range(0, 31)) | 32'd1;
      endcase
      rs = 1'($urandom);
      if (i == 7) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rs = 1'b1; end
      run_op(ra, rb, rs, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
